conv_sequencer: RTL and testbench

CONV_SEQUENCER -- requirements
Module: conv_sequencer

---
 rtl/conv_sequencer_pkg.sv | 32 +++
 rtl/conv_addr_gen.sv | 82 ++++++++
 rtl/conv_sequencer.sv | 242 ++++++++++++++++++++++++
 tb/tb_conv_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_sequencer_pkg.sv
// Shared state encoding and instruction-word layout for the convolution sequencer.
package conv_sequencer_pkg;

   typedef enum logic [3:0] {
      IDLE, W_L0, W_LOAD, W_DRAIN, A_L0, EXEC, E_DRAIN, PSUM_WR, ACC, ACC_OUT, DONE
   } state_e;

   localparam int unsigned INST_W     = 34;
   localparam int unsigned INST_AW    = 11;
   localparam int unsigned ACC_BIT    = 33;
   localparam int unsigned CEN_PMEM   = 32;
   localparam int unsigned WEN_PMEM   = 31;
   localparam int unsigned A_PMEM_LSB = 20;
   localparam int unsigned CEN_XMEM   = 19;
   localparam int unsigned WEN_XMEM   = 18;
   localparam int unsigned A_XMEM_LSB = 7;
   localparam int unsigned OFIFO_RD   = 6;
   localparam int unsigned IFIFO_WR   = 5;
   localparam int unsigned IFIFO_RD   = 4;
   localparam int unsigned L0_RD      = 3;
   localparam int unsigned L0_WR      = 2;
   localparam int unsigned EXECUTE    = 1;
   localparam int unsigned LOAD       = 0;

   // Both SRAMs deselected and write-disabled (active-low), everything else quiet.
   localparam logic [INST_W-1:0] INST_IDLE = 34'h1_800C_0000;

   function automatic int unsigned cw(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// ACC-phase pmem address: walks output pixels (o) and kernel taps (k) with add-only steps.
module conv_addr_gen
   import conv_sequencer_pkg::*;
#(
   parameter int unsigned LEN_NIJ  = 36,
   parameter int unsigned LEN_NI   = 6,
   parameter int unsigned LEN_KIJ  = 9,
   parameter int unsigned LEN_KI   = 3,
   parameter int unsigned LEN_ONIJ = 16,
   parameter int unsigned LEN_ONI  = 4,
   parameter int unsigned AW       = 11
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        clr,
   input  logic                        k_step,
   input  logic                        o_step,
   output logic [AW-1:0]               addr,
   output logic [$clog2(LEN_ONIJ)-1:0] o_idx,
   output logic                        k_last,
   output logic                        o_last
);

   localparam int unsigned KW  = cw(LEN_KIJ);
   localparam int unsigned KIW = cw(LEN_KI);
   localparam int unsigned OW  = $clog2(LEN_ONIJ);
   localparam int unsigned OIW = cw(LEN_ONI);
   // Next tap is the next psum bank plus one column, or one row down at a kernel-row wrap.
   localparam logic [AW-1:0] K_INC  = AW'(LEN_NIJ + 1);
   localparam logic [AW-1:0] K_WRAP = AW'(LEN_NIJ + LEN_NI - LEN_KI + 1);
   localparam logic [AW-1:0] O_WRAP = AW'(LEN_NI - LEN_ONI + 1);

   logic [KW-1:0]  k_q;
   logic [KIW-1:0] ki_q;
   logic [OW-1:0]  o_q;
   logic [OIW-1:0] oi_q;
   logic [AW-1:0]  kofs_q, obase_q;

   assign k_last = (k_q == KW'(LEN_KIJ - 1));
   assign o_last = (o_q == OW'(LEN_ONIJ - 1));
   assign addr   = obase_q + kofs_q;
   assign o_idx  = o_q;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         k_q     <= '0;
         ki_q    <= '0;
         o_q     <= '0;
         oi_q    <= '0;
         kofs_q  <= '0;
         obase_q <= '0;
      end else begin
         if (k_step) begin
            if (k_last) begin
               k_q    <= '0;
               ki_q   <= '0;
               kofs_q <= '0;
            end else begin
               k_q <= k_q + KW'(1);
               if (ki_q == KIW'(LEN_KI - 1)) begin
                  ki_q   <= '0;
                  kofs_q <= kofs_q + K_WRAP;
               end else begin
                  ki_q   <= ki_q + KIW'(1);
                  kofs_q <= kofs_q + K_INC;
               end
            end
         end
         if (o_step) begin
            o_q <= o_q + OW'(1);
            if (oi_q == OIW'(LEN_ONI - 1)) begin
               oi_q    <= '0;
               obase_q <= obase_q + O_WRAP;
            end else begin
               oi_q    <= oi_q + OIW'(1);
               obase_q <= obase_q + AW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/conv_sequencer.sv
// Sequences weight load, execute, psum write-back and output accumulation for one
// full convolution pass; every output is registered.
module conv_sequencer
   import conv_sequencer_pkg::*;
#(
   parameter int unsigned ROW      = 8,
   parameter int unsigned COL      = 8,
   parameter int unsigned LEN_NIJ  = 36,
   parameter int unsigned LEN_NI   = 6,
   parameter int unsigned LEN_KIJ  = 9,
   parameter int unsigned LEN_KI   = 3,
   parameter int unsigned LEN_ONIJ = 16,
   parameter int unsigned LEN_ONI  = 4,
   parameter int unsigned W_BASE   = 'h400,
   parameter int unsigned AW       = 11
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic                        ofifo_valid,
   output logic [INST_W-1:0]           inst,
   output logic                        sfp_clr,
   output logic                        out_valid,
   output logic [$clog2(LEN_ONIJ)-1:0] out_idx,
   output logic                        busy,
   output logic                        done
);

   localparam int unsigned OW      = $clog2(LEN_ONIJ);
   localparam int unsigned KW      = cw(LEN_KIJ);
   localparam int unsigned DRAIN_L = (2 * COL > ROW + COL) ? 2 * COL : ROW + COL;
   localparam int unsigned CNT_LIM = (LEN_NIJ > DRAIN_L) ? LEN_NIJ : DRAIN_L;
   localparam int unsigned CW      = cw(CNT_LIM);
   localparam logic [CW-1:0] COL_M1  = CW'(COL - 1);
   localparam logic [CW-1:0] WDR_M1  = CW'(2 * COL - 1);
   localparam logic [CW-1:0] NIJ_M1  = CW'(LEN_NIJ - 1);
   localparam logic [CW-1:0] EDR_M1  = CW'(ROW + COL - 1);
   localparam logic [KW-1:0] KIJ_M1  = KW'(LEN_KIJ - 1);

   if (AW != INST_AW) begin : g_aw_chk
      $error("AW must equal the inst address field width");
   end
   if (LEN_KIJ * LEN_NIJ > (2 ** AW) / 2) begin : g_pmem_chk
      $error("psum footprint exceeds half the address space");
   end
   if (W_BASE + LEN_KIJ * COL > 2 ** AW) begin : g_xmem_chk
      $error("weight region exceeds the address space");
   end

   state_e              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [KW-1:0]       kij_q, kij_d;
   logic [AW-1:0]       wa_q, wa_d, pw_addr_q, pw_addr_d;
   logic [INST_W-1:0]   inst_q, inst_d;
   logic                sfp_clr_q, sfp_clr_d, out_valid_q, out_valid_d;
   logic                done_q, done_d, busy_q;
   logic [OW-1:0]       out_idx_q, out_idx_d;
   logic                ag_clr, ag_k_step, ag_o_step, ag_k_last, ag_o_last;
   logic [AW-1:0]       ag_addr;
   logic [OW-1:0]       ag_o;

   conv_addr_gen #(
      .LEN_NIJ (LEN_NIJ),
      .LEN_NI  (LEN_NI),
      .LEN_KIJ (LEN_KIJ),
      .LEN_KI  (LEN_KI),
      .LEN_ONIJ(LEN_ONIJ),
      .LEN_ONI (LEN_ONI),
      .AW      (AW)
   ) u_addr_gen (
      .clk   (clk),
      .reset (reset),
      .clr   (ag_clr),
      .k_step(ag_k_step),
      .o_step(ag_o_step),
      .addr  (ag_addr),
      .o_idx (ag_o),
      .k_last(ag_k_last),
      .o_last(ag_o_last)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      kij_d       = kij_q;
      wa_d        = wa_q;
      pw_addr_d   = pw_addr_q;
      inst_d      = INST_IDLE;
      // SRAM read data arrives a cycle later, so L0 write and SFP accumulate trail the read.
      inst_d[L0_WR]   = ~inst_q[CEN_XMEM] & inst_q[WEN_XMEM];
      inst_d[ACC_BIT] = ~inst_q[CEN_PMEM] & inst_q[WEN_PMEM];
      sfp_clr_d   = 1'b0;
      out_valid_d = 1'b0;
      out_idx_d   = out_idx_q;
      done_d      = 1'b0;
      ag_clr      = 1'b0;
      ag_k_step   = 1'b0;
      ag_o_step   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = W_L0;
               cnt_d     = '0;
               kij_d     = '0;
               wa_d      = AW'(W_BASE);
               pw_addr_d = '0;
               ag_clr    = 1'b1;
            end
         end
         W_L0: begin
            inst_d[CEN_XMEM]               = 1'b0;
            inst_d[A_XMEM_LSB +: AW]       = wa_q;
            wa_d                           = wa_q + AW'(1);
            if (cnt_q == COL_M1) begin
               state_d = W_LOAD;
               cnt_d   = '0;
            end else cnt_d = cnt_q + CW'(1);
         end
         W_LOAD: begin
            inst_d[L0_RD] = 1'b1;
            inst_d[LOAD]  = 1'b1;
            if (cnt_q == COL_M1) begin
               state_d = W_DRAIN;
               cnt_d   = '0;
            end else cnt_d = cnt_q + CW'(1);
         end
         W_DRAIN: begin
            if (cnt_q == WDR_M1) begin
               state_d = A_L0;
               cnt_d   = '0;
            end else cnt_d = cnt_q + CW'(1);
         end
         A_L0: begin
            inst_d[CEN_XMEM]         = 1'b0;
            inst_d[A_XMEM_LSB +: AW] = AW'(cnt_q);
            if (cnt_q == NIJ_M1) begin
               state_d = EXEC;
               cnt_d   = '0;
            end else cnt_d = cnt_q + CW'(1);
         end
         EXEC: begin
            inst_d[EXECUTE] = 1'b1;
            inst_d[L0_RD]   = 1'b1;
            if (cnt_q == NIJ_M1) begin
               state_d = E_DRAIN;
               cnt_d   = '0;
            end else cnt_d = cnt_q + CW'(1);
         end
         E_DRAIN: begin
            if (cnt_q == EDR_M1) begin
               state_d = PSUM_WR;
               cnt_d   = '0;
            end else cnt_d = cnt_q + CW'(1);
         end
         PSUM_WR: begin
            // An empty OFIFO just holds the row count and address until data shows up.
            if (ofifo_valid) begin
               inst_d[OFIFO_RD]         = 1'b1;
               inst_d[CEN_PMEM]         = 1'b0;
               inst_d[WEN_PMEM]         = 1'b0;
               inst_d[A_PMEM_LSB +: AW] = pw_addr_q;
               pw_addr_d                = pw_addr_q + AW'(1);
               if (cnt_q == NIJ_M1) begin
                  cnt_d = '0;
                  if (kij_q == KIJ_M1) state_d = ACC;
                  else begin
                     kij_d   = kij_q + KW'(1);
                     state_d = W_L0;
                  end
               end else cnt_d = cnt_q + CW'(1);
            end
         end
         ACC: begin
            inst_d[CEN_PMEM]         = 1'b0;
            inst_d[A_PMEM_LSB +: AW] = ag_addr;
            ag_k_step                = 1'b1;
            if (ag_k_last) begin
               state_d = ACC_OUT;
               cnt_d   = '0;
            end
         end
         ACC_OUT: begin
            // Slot 0 lets the last accumulate land; slot 1 publishes, slot 2 clears.
            if (cnt_q == CW'(0)) cnt_d = CW'(1);
            else if (cnt_q == CW'(1)) begin
               out_valid_d = 1'b1;
               out_idx_d   = ag_o;
               cnt_d       = CW'(2);
            end else begin
               sfp_clr_d = 1'b1;
               cnt_d     = '0;
               if (ag_o_last) state_d = DONE;
               else begin
                  ag_o_step = 1'b1;
                  state_d   = ACC;
               end
            end
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         kij_q       <= '0;
         wa_q        <= '0;
         pw_addr_q   <= '0;
         inst_q      <= INST_IDLE;
         sfp_clr_q   <= 1'b1;
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         kij_q       <= kij_d;
         wa_q        <= wa_d;
         pw_addr_q   <= pw_addr_d;
         inst_q      <= inst_d;
         sfp_clr_q   <= sfp_clr_d;
         out_valid_q <= out_valid_d;
         out_idx_q   <= out_idx_d;
         done_q      <= done_d;
         busy_q      <= (state_d != IDLE);
      end
   end

   assign inst      = inst_q;
   assign sfp_clr   = sfp_clr_q;
   assign out_valid = out_valid_q;
   assign out_idx   = out_idx_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench: default-size pass, stall/restart/reset disturbances, and a reduced geometry.
module tb_conv_sequencer;

   localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;
   localparam int unsigned W_BASE    = 'h400;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, start, ofifo_valid, start_s, ofifo_valid_s, sb_clr;
   logic [33:0] inst, inst_s;
   logic        sfp_clr, out_valid, busy, done;
   logic        sfp_clr_s, out_valid_s, busy_s, done_s;
   logic [3:0]  out_idx, out_idx_s;

   conv_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .ofifo_valid(ofifo_valid),
      .inst       (inst),
      .sfp_clr    (sfp_clr),
      .out_valid  (out_valid),
      .out_idx    (out_idx),
      .busy       (busy),
      .done       (done)
   );

   conv_sequencer #(
      .ROW(4), .COL(4), .LEN_NIJ(16), .LEN_NI(4), .LEN_KIJ(4), .LEN_KI(2),
      .LEN_ONIJ(9), .LEN_ONI(3)
   ) dut_s (
      .clk        (clk),
      .reset      (reset),
      .start      (start_s),
      .ofifo_valid(ofifo_valid_s),
      .inst       (inst_s),
      .sfp_clr    (sfp_clr_s),
      .out_valid  (out_valid_s),
      .out_idx    (out_idx_s),
      .busy       (busy_s),
      .done       (done_s)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int acc_addr(input int o, input int k, input int nij, input int ni,
                                   input int oni, input int ki);
      return k * nij + (o / oni) * ni + o % oni + (k / ki) * ni + k % ki;
   endfunction

   logic        pwr, prd, xrd, pwr_s, prd_s, xrd_s;
   logic [10:0] ap, ax, ap_s, ax_s;
   assign pwr   = !inst[32] && !inst[31];
   assign prd   = !inst[32] && inst[31];
   assign xrd   = !inst[19] && inst[18];
   assign ap    = inst[30:20];
   assign ax    = inst[17:7];
   assign pwr_s = !inst_s[32] && !inst_s[31];
   assign prd_s = !inst_s[32] && inst_s[31];
   assign xrd_s = !inst_s[19] && inst_s[18];
   assign ap_s  = inst_s[30:20];
   assign ax_s  = inst_s[17:7];

   // Scoreboard for the default-size instance.
   int   cyc = 0;
   int   wr_cnt, rd_cnt, acc_cnt, wrd_cnt, act_cnt, l0wr_cnt, ov_cnt, done_cnt;
   int   clr_cyc, done_cyc, start_cyc, dur;
   logic probe_q = 1'b0, busy_prev = 1'b0;

   always @(negedge clk) begin
      cyc       <= cyc + 1;
      busy_prev <= busy;
      if (sb_clr) begin
         wr_cnt <= 0; rd_cnt <= 0; acc_cnt <= 0; wrd_cnt <= 0; act_cnt <= 0;
         l0wr_cnt <= 0; ov_cnt <= 0; done_cnt <= 0; clr_cyc <= 0; done_cyc <= 0; dur <= 0;
         probe_q <= 1'b0;
      end else begin
         if (busy && !busy_prev) start_cyc <= cyc;
         if (probe_q) check("acc_after_o5k4", inst[33], 1);
         probe_q <= 1'b0;
         if (pwr) begin
            check("pmem_wr_addr", ap, wr_cnt);
            wr_cnt <= wr_cnt + 1;
         end
         if (prd) begin
            check("acc_rd_addr", ap, acc_addr(rd_cnt / 9, rd_cnt % 9, 36, 6, 4, 3));
            if (rd_cnt == 5 * 9 + 4) begin
               check("acc_o5k4_addr", ap, 158);
               probe_q <= 1'b1;
            end
            rd_cnt <= rd_cnt + 1;
         end
         if (inst[33]) acc_cnt <= acc_cnt + 1;
         if (inst[2]) l0wr_cnt <= l0wr_cnt + 1;
         if (xrd) begin
            if (ax >= 11'(W_BASE)) begin
               check("w_rd_addr", ax, W_BASE + wrd_cnt);
               wrd_cnt <= wrd_cnt + 1;
            end else act_cnt <= act_cnt + 1;
         end
         if (out_valid) begin
            check("out_idx", out_idx, ov_cnt);
            ov_cnt <= ov_cnt + 1;
         end
         if (sfp_clr) clr_cyc <= cyc;
         if (done) begin
            done_cyc <= cyc;
            dur      <= cyc - start_cyc;
            done_cnt <= done_cnt + 1;
         end
      end
   end

   // Scoreboard for the reduced-geometry instance.
   int   wr_s, rd_s, wrd_s, ov_s, clr_cyc_s, done_cyc_s, start_cyc_s, dur_s;
   logic busy_prev_s = 1'b0;

   always @(negedge clk) begin
      busy_prev_s <= busy_s;
      if (sb_clr) begin
         wr_s <= 0; rd_s <= 0; wrd_s <= 0; ov_s <= 0; clr_cyc_s <= 0; done_cyc_s <= 0;
         dur_s <= 0;
      end else begin
         if (busy_s && !busy_prev_s) start_cyc_s <= cyc;
         if (pwr_s) begin
            check("s_pmem_wr_addr", ap_s, wr_s);
            wr_s <= wr_s + 1;
         end
         if (prd_s) begin
            check("s_acc_rd_addr", ap_s, acc_addr(rd_s / 4, rd_s % 4, 16, 4, 3, 2));
            rd_s <= rd_s + 1;
         end
         if (xrd_s && ax_s >= 11'(W_BASE)) begin
            check("s_w_rd_addr", ax_s, W_BASE + wrd_s);
            wrd_s <= wrd_s + 1;
         end
         if (out_valid_s) begin
            check("s_out_idx", out_idx_s, ov_s);
            ov_s <= ov_s + 1;
         end
         if (sfp_clr_s) clr_cyc_s <= cyc;
         if (done_s) begin
            done_cyc_s <= cyc;
            dur_s      <= cyc - start_cyc_s;
         end
      end
   end

   task automatic clear_sb();
      sb_clr = 1'b1;
      repeat (2) @(negedge clk);
      sb_clr = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int limit, output bit seen);
      int n = 0;
      while (!done && n < limit) begin
         @(negedge clk);
         n++;
      end
      seen = done;
      @(negedge clk);
   endtask

   initial begin
      bit ok;
      int n, nw;
      reset = 1'b1; start = 1'b0; start_s = 1'b0;
      ofifo_valid = 1'b1; ofifo_valid_s = 1'b1; sb_clr = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_inst", inst, IDLE_INST);
      check("rst_busy", busy, 0);
      check("rst_sfp_clr", sfp_clr, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_done", done, 0);
      check("rst_inst_s", inst_s, IDLE_INST);
      reset = 1'b0;
      @(negedge clk);

      // Pass 1: undisturbed default pass.
      clear_sb();
      pulse_start();
      wait_done(3000, ok);
      check("p1_done_seen", ok, 1);
      check("p1_duration", dur, 1597);
      check("p1_pmem_writes", wr_cnt, 324);
      check("p1_acc_reads", rd_cnt, 144);
      check("p1_acc_cycles", acc_cnt, 144);
      check("p1_weight_reads", wrd_cnt, 72);
      check("p1_act_reads", act_cnt, 324);
      check("p1_l0_writes", l0wr_cnt, 396);
      check("p1_out_pulses", ov_cnt, 16);
      check("p1_done_pulses", done_cnt, 1);
      check("p1_done_after_clr", done_cyc - clr_cyc, 1);
      check("p1_idle_busy", busy, 0);

      // Pass 2: start re-pulsed while busy plus a 10-cycle OFIFO stall at kij=2.
      clear_sb();
      pulse_start();
      repeat (60) @(negedge clk);
      check("p2_busy_mid", busy, 1);
      pulse_start();
      n = 0;
      while (!(pwr && ap == 11'd80) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("p2_stall_trigger", pwr && ap == 11'd80, 1);
      ofifo_valid = 1'b0;
      nw = 0;
      repeat (10) begin
         @(negedge clk);
         if (pwr) nw++;
      end
      check("p2_stall_no_writes", nw, 0);
      ofifo_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!pwr && n < 50);
      check("p2_resume_addr", ap, 81);
      n = 0;
      while (ov_cnt < 3 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      pulse_start();
      check("p2_busy_acc", busy, 1);
      wait_done(3000, ok);
      check("p2_done_seen", ok, 1);
      check("p2_duration", dur, 1607);
      check("p2_pmem_writes", wr_cnt, 324);
      check("p2_out_pulses", ov_cnt, 16);
      check("p2_done_pulses", done_cnt, 1);

      // Pass 3: reset during EXEC at kij=3.
      clear_sb();
      pulse_start();
      n = 0;
      while (!(inst[1] && wrd_cnt == 32) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("p3_exec_kij3_trigger", inst[1] && wrd_cnt == 32, 1);
      reset = 1'b1;
      @(negedge clk);
      check("p3_rst_inst", inst, IDLE_INST);
      check("p3_rst_busy", busy, 0);
      check("p3_rst_no_pmem_wr", pwr, 0);
      check("p3_rst_sfp_clr", sfp_clr, 1);
      check("p3_rst_out_valid", out_valid, 0);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("p3_stays_idle", busy, 0);
      check("p3_inst_idle", inst, IDLE_INST);

      // Pass 4: reduced geometry.
      clear_sb();
      start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      n = 0;
      while (!done_s && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("s_done_seen", done_s, 1);
      @(negedge clk);
      check("s_duration", dur_s, 352);
      check("s_pmem_writes", wr_s, 64);
      check("s_acc_reads", rd_s, 36);
      check("s_weight_reads", wrd_s, 16);
      check("s_out_pulses", ov_s, 9);
      check("s_done_after_clr", done_cyc_s - clr_cyc_s, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
